// File: rtl/div_unit_32bit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per clock,
// quotient to LO, remainder to HI, with a one-cycle done pulse.
module div_unit_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   remWide, trial;
  logic [WIDTH-1:0] remNext, quoNext, dividendMag, divisorMag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      count_q     <= '0;
      negQuo_q    <= 1'b0;
      negRem_q    <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      count_q     <= count_d;
      negQuo_q    <= negQuo_d;
      negRem_q    <= negRem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    count_d     = count_q;
    negQuo_d    = negQuo_q;
    negRem_d    = negRem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    dividendMag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    divisorMag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The shifted partial remainder can exceed WIDTH bits, so the trial runs one bit wider.
    remWide = {rem_q, quo_q[WIDTH-1]};
    trial   = remWide - {1'b0, dvsr_q};
    if (trial[WIDTH]) begin
      remNext = remWide[WIDTH-1:0];
      quoNext = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      remNext = trial[WIDTH-1:0];
      quoNext = {quo_q[WIDTH-2:0], 1'b1};
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          negQuo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negRem_d = is_signed & dividend[WIDTH-1];
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = dividendMag;
            dvsr_d  = divisorMag;
            count_d = '0;
            dbz_d   = 1'b0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d   = remNext;
        quo_d   = quoNext;
        count_d = count_q + CW'(1);
        // Negating the most-negative magnitude wraps back onto itself, giving the overflow result.
        if (count_q == LAST) begin
          quotient_d  = negQuo_q ? -quoNext : quoNext;
          remainder_d = negRem_q ? -remNext : remNext;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit_32bit.sv
// Directed self-checking bench for div_unit_32bit: latency, unsigned/signed
// results, divide-by-zero, overflow, busy rejection and mid-divide reset.
module tb_div_unit_32bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        isSigned;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  int errors;
  int checks;

  div_unit_32bit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (isSigned),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (divByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and counts edges (including the accepting one) until done.
  // A stuck divider returns 50, which no caller accepts.
  task automatic runDiv(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    for (int n = 0; n < 5 && busy; n++) tick();
    isSigned = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    cycles   = 0;
    do begin
      tick();
      start = 1'b0;
      cycles++;
    end while (!done && cycles < 50);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("[TB] FAIL reset_q got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("[TB] FAIL reset_r got=%h exp=0", remainder); end
    checks++; if (divByZero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz got=%b exp=0", divByZero); end
  endtask

  task automatic test_unsigned();
    int cyc;
    runDiv(1'b0, 32'd100, 32'd7, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL divu100_latency got=%0d exp=33", cyc); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL divu100_q got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("[TB] FAIL divu100_r got=%0d exp=2", remainder); end
    checks++; if (divByZero !== 1'b0) begin errors++; $display("[TB] FAIL divu100_dbz got=%b exp=0", divByZero); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL done_pulse got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL hold_q got=%0d exp=14", quotient); end

    runDiv(1'b0, 32'd2500000000, 32'd3, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL divu_big_latency got=%0d exp=33", cyc); end
    checks++; if (quotient !== 32'd833333333) begin errors++; $display("[TB] FAIL divu_big_q got=%0d exp=833333333", quotient); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("[TB] FAIL divu_big_r got=%0d exp=1", remainder); end
  endtask

  task automatic test_signed();
    int cyc;
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (quotient !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_m7_2_q got=%h exp=fffffffd", quotient); end
    checks++; if (remainder !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_m7_2_r got=%h exp=ffffffff", remainder); end
    runDiv(1'b1, 32'd7, 32'hFFFF_FFFE, cyc);
    checks++; if (quotient !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_7_m2_q got=%h exp=fffffffd", quotient); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("[TB] FAIL div_7_m2_r got=%h exp=1", remainder); end
    runDiv(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, cyc);
    checks++; if (quotient !== 32'd3) begin errors++; $display("[TB] FAIL div_m7_m2_q got=%h exp=3", quotient); end
    checks++; if (remainder !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_m7_m2_r got=%h exp=ffffffff", remainder); end
    // Same bit pattern unsigned: 4294967289 / 2.
    runDiv(1'b0, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (quotient !== 32'h7FFF_FFFC) begin errors++; $display("[TB] FAIL divu_fff9_q got=%h exp=7ffffffc", quotient); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("[TB] FAIL divu_fff9_r got=%h exp=1", remainder); end
  endtask

  task automatic test_corner();
    int cyc;
    runDiv(1'b0, 32'd5, 32'd0, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("[TB] FAIL dbz_latency got=%0d exp=1", cyc); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL dbz_q got=%h exp=ffffffff", quotient); end
    checks++; if (remainder !== 32'd5) begin errors++; $display("[TB] FAIL dbz_r got=%h exp=5", remainder); end
    checks++; if (divByZero !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag got=%b exp=1", divByZero); end
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL ovf_latency got=%0d exp=33", cyc); end
    checks++; if (quotient !== 32'h8000_0000) begin errors++; $display("[TB] FAIL ovf_q got=%h exp=80000000", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("[TB] FAIL ovf_r got=%h exp=0", remainder); end
    checks++; if (divByZero !== 1'b0) begin errors++; $display("[TB] FAIL ovf_dbz got=%b exp=0", divByZero); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int n = 0; n < 5 && busy; n++) tick();
    isSigned = 1'b0;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    cyc      = 0;
    do begin
      tick();
      start = 1'b0;
      cyc++;
      if (cyc == 2) begin
        dividend = 32'd55;
        divisor  = 32'd4;
      end
      if (cyc == 9) begin
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
      end
    end while (!done && cyc < 50);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL ignore_latency got=%0d exp=33", cyc); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL ignore_q got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("[TB] FAIL ignore_r got=%0d exp=2", remainder); end
    tick();
    runDiv(1'b0, 32'd9, 32'd3, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL b2b_latency got=%0d exp=33", cyc); end
    checks++; if (quotient !== 32'd3) begin errors++; $display("[TB] FAIL b2b_q got=%0d exp=3", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("[TB] FAIL b2b_r got=%0d exp=0", remainder); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    runDiv(1'b0, 32'd5, 32'd0, cyc);
    tick();
    isSigned = 1'b0;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy got=%b exp=1", busy); end
    checks++; if (divByZero !== 1'b0) begin errors++; $display("[TB] FAIL mid_dbz_clear got=%b exp=0", divByZero); end
    checks++; if (quotient !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mid_hold_q got=%h exp=ffffffff", quotient); end
    for (int n = 0; n < 9; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_done got=%b exp=0", done); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_q got=%h exp=0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_r got=%h exp=0", remainder); end
    runDiv(1'b0, 32'd100, 32'd7, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("[TB] FAIL rst_after_latency got=%0d exp=33", cyc); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("[TB] FAIL rst_after_q got=%0d exp=14", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("[TB] FAIL rst_after_r got=%0d exp=2", remainder); end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    isSigned = 1'b0;
    dividend = 32'h0;
    divisor  = 32'h0;
    test_reset();
    test_unsigned();
    test_signed();
    test_corner();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
